rr_grant_seq: RTL and testbench
===============================

RR_GRANT_SEQ -- requirements
Module: rr_grant_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles a grant is held without done (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-004 SHALL have port req, input, 4, request lines; req[i] high means channel i requests.
REQ-005 SHALL have port done, input, 1, the granted channel releases the grant.
REQ-006 SHALL have port grant_idx, output, 2, registered binary index of the granted channel; drives the downstream 2-to-4 decoder select.
REQ-007 SHALL have port grant_vld, output, 1, registered; high while grant_idx is a live grant.
REQ-008 SHALL have port timeout, output, 1, registered one-cycle pulse on forced release.

Function
REQ-009 SHALL implement two states: IDLE and GRANT.
REQ-010 SHALL keep internal pointer last[1:0], the index of the most recently released grant.
REQ-011 In IDLE with req != 0, SHALL select the first set req bit in the order last+1, last+2, last+3, last (mod 4, wrap from 3 to 0).
REQ-012 On that edge, SHALL load grant_idx with the selected index, set grant_vld=1, clear the hold counter and enter GRANT; latency is one edge from sampled req to grant_vld.
REQ-013 In IDLE with req == 0, SHALL remain in IDLE, keep grant_vld=0 and hold grant_idx at its previous value.
REQ-014 In GRANT, SHALL hold grant_idx and grant_vld=1 regardless of req changes, including deassertion of the granted req bit.
REQ-015 In GRANT, SHALL increment the hold counter every cycle done is low.
REQ-016 In GRANT with done=1, SHALL on that edge set last=grant_idx, grant_vld=0 and enter IDLE.
REQ-017 In GRANT with done=0 and the hold counter equal to TIMEOUT-1, SHALL on that edge release as in REQ-016 and set timeout=1 for exactly one cycle.
REQ-018 When done=1 and the timeout condition coincide, SHALL treat the event as a normal release with timeout=0.
REQ-019 After any release, SHALL spend at least one cycle in IDLE before the next grant, so grant_vld has a minimum one-cycle low gap between grants.
REQ-020 SHALL ignore done while in IDLE, with no effect on state, outputs or last.
REQ-021 SHALL size the hold counter at 8 bits; it SHALL never wrap while in GRANT.
REQ-022 SHALL drive timeout=0 in every cycle other than the pulse of REQ-017.

Reset
REQ-023 rst=1 SHALL on the next edge force state=IDLE, grant_idx=0, grant_vld=0, timeout=0, hold counter=0 and last=3, so channel 0 has first priority.
REQ-024 rst asserted during GRANT SHALL abort the grant without updating last beyond the value 3, and SHALL take priority over done and timeout.
REQ-025 While rst=1, SHALL ignore req and done.

Verification
REQ-026 Reset, then req=4'b1111 -> grant_idx=0 with grant_vld=1 one edge later; done pulse -> grants proceed 1, 2, 3, 0 with a one-cycle grant_vld=0 gap between each.
REQ-027 last=3 (after reset), req=4'b1000 -> grant_idx=3; release; req=4'b1001 -> grant_idx=0, confirming wrap-around from 3.
REQ-028 Grant on channel 2, done held low for 16 cycles with TIMEOUT=16 -> release on the 16th GRANT edge, timeout=1 for one cycle, next grant starts from channel 3.
REQ-029 done=1 on the same edge the counter reaches TIMEOUT-1 -> release with timeout=0.
REQ-030 Grant on channel 1, deassert req[1] while done=0 -> grant_idx stays 1 and grant_vld stays 1 until done.
REQ-031 rst=1 mid-GRANT on channel 2 -> next edge grant_vld=0, grant_idx=0; then req=4'b0100 -> grant_idx=2.

Source files
------------

// File: rtl/rr_grant_seq.sv
// rr_grant_seq: round-robin arbiter over 4 requesters. It holds one grant until done or until TIMEOUT cycles pass.
module rr_grant_seq #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] grant_idx,
   output logic       grant_vld,
   output logic       timeout
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [1:0] last, last_n, idx_n, sel;
   logic       vld_n, to_n;
   // Scan from last+4 (== last) down to last+1 so the lowest offset with a set bit wins.
   always_comb begin
      sel = last;
      for (int k = 4; k >= 1; k--)
         if (req[2'(last + 2'(k))]) sel = 2'(last + 2'(k));
   end
   always_comb begin
      state_n = state;
      idx_n   = grant_idx;
      vld_n   = grant_vld;
      to_n    = 1'b0;
      cnt_n   = cnt;
      last_n  = last;
      if (state == IDLE) begin
         if (|req) begin
            state_n = GRANT;
            idx_n   = sel;
            vld_n   = 1'b1;
            cnt_n   = 8'd0;
         end
      end else if (done || cnt == 8'(TIMEOUT - 1)) begin
         state_n = IDLE;
         vld_n   = 1'b0;
         last_n  = grant_idx;
         to_n    = !done;
      end else
         cnt_n = cnt + 8'd1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_idx <= 2'd0;
         grant_vld <= 1'b0;
         timeout   <= 1'b0;
         cnt       <= 8'd0;
         last      <= 2'd3;
      end else begin
         state     <= state_n;
         grant_idx <= idx_n;
         grant_vld <= vld_n;
         timeout   <= to_n;
         cnt       <= cnt_n;
         last      <= last_n;
      end
   end
endmodule

// File: tb/tb_rr_grant_seq.sv
// tb_rr_grant_seq: directed checks of rotation, wrap-around, timeout, request drop and mid-grant reset.
module tb_rr_grant_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'd0;
   logic       done = 1'b0;
   logic [1:0] grant_idx;
   logic       grant_vld;
   logic       timeout;
   int n_checks = 0;
   int n_fail = 0;
   rr_grant_seq #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant_idx(grant_idx), .grant_vld(grant_vld), .timeout(timeout)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; done = 1'b1;
      step();
      n_checks++;
      if ({grant_vld, grant_idx, timeout} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state: vld=%b idx=%0d to=%b, want vld=0 idx=0 to=0", grant_vld, grant_idx, timeout);
      end
      rst = 1'b0; req = 4'b0000; done = 1'b0;
      step();
      n_checks++;
      if (grant_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: vld=%b, want 0", grant_vld);
      end
   endtask
   task automatic test_rotation();
      logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (grant_vld !== 1'b1 || grant_idx !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL rotation_grant[%0d]: vld=%b idx=%0d, want vld=1 idx=%0d", i, grant_vld, grant_idx, exp_seq[i]);
         end
         done = 1'b1;
         step();
         done = 1'b0;
         n_checks++;
         if (grant_vld !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_gap[%0d]: vld=%b to=%b, want vld=0 to=0", i, grant_vld, timeout);
         end
      end
      req = 4'b0000;
   endtask
   task automatic test_wrap();
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'b1000;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL wrap_first: vld=%b idx=%0d, want vld=1 idx=3", grant_vld, grant_idx);
      end
      done = 1'b1; req = 4'b1001;
      step();
      done = 1'b0;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL wrap_second: vld=%b idx=%0d, want vld=1 idx=0", grant_vld, grant_idx);
      end
      done = 1'b1; req = 4'b0000;
      step();
      done = 1'b0;
   endtask
   task automatic test_timeout();
      req = 4'b0100;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL timeout_grant: vld=%b idx=%0d, want vld=1 idx=2", grant_vld, grant_idx);
      end
      for (int i = 1; i <= 15; i++) begin
         step();
         n_checks++;
         if (grant_vld !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hold[%0d]: vld=%b to=%b, want vld=1 to=0", i, grant_vld, timeout);
         end
      end
      req = 4'b1111;
      step();
      n_checks++;
      if (grant_vld !== 1'b0 || timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_release: vld=%b to=%b, want vld=0 to=1", grant_vld, timeout);
      end
      step();
      n_checks++;
      if (timeout !== 1'b0 || grant_vld !== 1'b1 || grant_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL timeout_next: to=%b vld=%b idx=%0d, want to=0 vld=1 idx=3", timeout, grant_vld, grant_idx);
      end
      done = 1'b1; req = 4'b0000;
      step();
      done = 1'b0;
   endtask
   task automatic test_done_at_timeout();
      req = 4'b0001;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL coincide_grant: vld=%b idx=%0d, want vld=1 idx=0", grant_vld, grant_idx);
      end
      req = 4'b0000;
      repeat (15) step();
      done = 1'b1;
      step();
      done = 1'b0;
      n_checks++;
      if (grant_vld !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL coincide_release: vld=%b to=%b, want vld=0 to=0", grant_vld, timeout);
      end
      step();
      n_checks++;
      if (grant_vld !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL coincide_after: vld=%b to=%b, want vld=0 to=0", grant_vld, timeout);
      end
   endtask
   task automatic test_req_drop();
      logic [3:0] req_seq [3] = '{4'b0000, 4'b1101, 4'b0000};
      req = 4'b0010;
      step();
      for (int i = 0; i < 3; i++) begin
         req = req_seq[i];
         step();
         n_checks++;
         if (grant_vld !== 1'b1 || grant_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL req_drop_hold[%0d]: vld=%b idx=%0d, want vld=1 idx=1", i, grant_vld, grant_idx);
         end
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_checks++;
      if (grant_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL req_drop_release: vld=%b, want 0", grant_vld);
      end
   endtask
   task automatic test_reset_mid_grant();
      req = 4'b0100;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL midrst_grant: vld=%b idx=%0d, want vld=1 idx=2", grant_vld, grant_idx);
      end
      rst = 1'b1; done = 1'b1;
      step();
      rst = 1'b0; done = 1'b0;
      n_checks++;
      if (grant_vld !== 1'b0 || grant_idx !== 2'd0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_abort: vld=%b idx=%0d to=%b, want vld=0 idx=0 to=0", grant_vld, grant_idx, timeout);
      end
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL midrst_regrant: vld=%b idx=%0d, want vld=1 idx=2", grant_vld, grant_idx);
      end
      done = 1'b1; req = 4'b0000;
      step();
      done = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'b1110;
      step();
      n_checks++;
      if (grant_vld !== 1'b1 || grant_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL midrst_last3: vld=%b idx=%0d, want vld=1 idx=1", grant_vld, grant_idx);
      end
   endtask
   initial begin
      test_reset();
      test_rotation();
      test_wrap();
      test_timeout();
      test_done_at_timeout();
      test_req_drop();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
